// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: RAM strobe levels,
// loader state encoding and opcodes that appear in test images.
package program_loader_pkg;

    localparam logic RAM_WRITE = 1'b0;
    localparam logic RAM_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    localparam logic [3:0] OP_LOAD_IMM = 4'b0110;
    localparam logic [3:0] OP_STORE    = 4'b1110;
    localparam logic [3:0] OP_ADD      = 4'b0000;
    localparam logic [3:0] OP_NOP      = 4'b1111;

    // States from which a new load may be launched.
    function automatic logic is_restartable(input loader_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/program_loader_byte_word_packer.sv
// Shifts accepted bytes MSB-first into a 32-bit word and flags the byte
// that completes each word.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        word_done
);

    logic [31:0] word;
    logic [1:0]  count;

    assign word_next = {word[23:0], byte_data};
    assign word_done = take && !clear && (count == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (take) begin
            word  <= word_next;
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: packs a byte stream into 32-bit words, writes them to the
// instruction RAM, verifies a trailing checksum and then releases the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'd0,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [15:0]   load_words,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          mem_enable,
    output logic          mem_read_write,
    output logic [15:0]   mem_address,
    output logic [31:0]   mem_data_in,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_run,
    output loader_state_t debug_state
);

    loader_state_t state;
    logic [15:0]   words_q;
    logic [15:0]   index;
    logic [31:0]   sum;
    logic [31:0]   word_next;
    logic          word_done;
    logic          can_start;
    logic          take;

    // Byte handshake: a byte moves when byte_valid && byte_ready at a rising
    // clk edge; abort in the same cycle suppresses the transfer.
    assign can_start   = start && is_restartable(state);
    assign take        = byte_valid && byte_ready && !abort;
    assign debug_state = state;

    byte_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (abort || can_start),
        .take      (take),
        .byte_data (byte_data),
        .word_next (word_next),
        .word_done (word_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            words_q        <= '0;
            index          <= '0;
            sum            <= '0;
            byte_ready     <= 1'b0;
            mem_enable     <= 1'b0;
            mem_read_write <= RAM_READ;
            mem_address    <= '0;
            mem_data_in    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_run        <= 1'b0;
        end else if (abort) begin
            state          <= ST_IDLE;
            byte_ready     <= 1'b0;
            mem_enable     <= 1'b0;
            mem_read_write <= RAM_READ;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cpu_run        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        words_q <= load_words;
                        index   <= '0;
                        sum     <= '0;
                        done    <= 1'b0;
                        cpu_run <= 1'b0;
                        if (load_words > MAX_WORDS) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= (load_words == 16'd0) ? ST_CKSUM : ST_RECV;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_done) begin
                        state          <= ST_WRITE;
                        byte_ready     <= 1'b0;
                        mem_enable     <= 1'b1;
                        mem_read_write <= RAM_WRITE;
                        mem_address    <= BASE_ADDR + index;
                        mem_data_in    <= word_next;
                        sum            <= sum + word_next;
                        index          <= index + 16'd1;
                    end
                end
                ST_WRITE: begin
                    // index already counts the word just written
                    state          <= (index == words_q) ? ST_CKSUM : ST_RECV;
                    byte_ready     <= 1'b1;
                    mem_enable     <= 1'b0;
                    mem_read_write <= RAM_READ;
                end
                ST_CKSUM: begin
                    if (word_done) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (word_next == sum) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
